// File: rtl/single_cache_control_if.sv
// Signal bundle between the cache controller and its CPU/datapath/memory environment.
// slave = controller side, master = environment side.
interface single_cache_control_if #(
  parameter int s_way  = 2,
  parameter int s_mask = 32
);
  localparam int s_way_num = 2 ** s_way;
  localparam int s_plru    = s_way_num - 1;

  logic                 mem_read;
  logic                 mem_write;
  logic [s_mask-1:0]    mem_byte_en;
  logic                 mem_resp;
  logic                 pmem_read;
  logic                 pmem_write;
  logic                 pmem_resp;
  logic                 pmem_addr_sel;
  logic                 hit;
  logic                 valid_o;
  logic                 dirty_o;
  logic [s_way-1:0]     way_index;
  logic [s_plru-1:0]    plru_o;
  logic [s_way_num-1:0] data_we;
  logic [s_way_num-1:0] tag_we;
  logic [s_way_num-1:0] dirty_we;
  logic [s_way_num-1:0] valid_we;
  logic                 plru_we;
  logic [s_mask-1:0]    mask_val;
  logic                 data_in_sel;
  logic                 data_out_sel;
  logic                 valid_i;
  logic                 dirty_i;
  logic [s_plru-1:0]    plru_i;
  logic [s_way-1:0]     evict_index;

  modport slave (
    input  mem_read, mem_write, mem_byte_en, pmem_resp, hit, valid_o, dirty_o,
           way_index, plru_o,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_we, tag_we,
           dirty_we, valid_we, plru_we, mask_val, data_in_sel, data_out_sel,
           valid_i, dirty_i, plru_i, evict_index
  );

  modport master (
    output mem_read, mem_write, mem_byte_en, pmem_resp, hit, valid_o, dirty_o,
           way_index, plru_o,
    input  mem_resp, pmem_read, pmem_write, pmem_addr_sel, data_we, tag_we,
           dirty_we, valid_we, plru_we, mask_val, data_in_sel, data_out_sel,
           valid_i, dirty_i, plru_i, evict_index
  );
endinterface

// File: rtl/single_cache_control.sv
// Control FSM for one set-associative cache: hit handling, dirty writeback,
// line allocate/refill and tree-PLRU maintenance. Datapath strobes decode from state and inputs.
module single_cache_control #(
  parameter int s_way  = 2,
  parameter int s_mask = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  single_cache_control_if.slave bus
);
  localparam int s_way_num = 2 ** s_way;
  localparam int s_plru    = s_way_num - 1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_e;

  state_e state_q, state_d;

  logic [s_way-1:0]     evict;
  logic [s_way_num-1:0] wayOh;
  logic [s_way_num-1:0] evictOh;
  logic                 realHit;

  // Every node on the accessed way's path is pointed at the sibling subtree.
  function automatic logic [s_plru-1:0] plruTouch(input logic [s_plru-1:0] cur,
                                                  input logic [s_way-1:0]  way);
    logic [s_plru-1:0] nxt;
    int                node;
    nxt  = cur;
    node = 0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      nxt[node] = ~way[s_way-1-lvl];
      node      = 2 * node + 1 + (way[s_way-1-lvl] ? 1 : 0);
    end
    return nxt;
  endfunction

  always_comb begin
    int node;
    evict = '0;
    node  = 0;
    for (int lvl = 0; lvl < s_way; lvl++) begin
      evict[s_way-1-lvl] = bus.plru_o[node];
      node               = 2 * node + 1 + (bus.plru_o[node] ? 1 : 0);
    end
  end

  assign bus.evict_index = evict;
  assign wayOh           = {{(s_way_num-1){1'b0}}, 1'b1} << bus.way_index;
  assign evictOh         = {{(s_way_num-1){1'b0}}, 1'b1} << evict;
  assign realHit         = bus.hit & bus.valid_o;

  always_comb begin
    state_d           = state_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.data_we       = '0;
    bus.tag_we        = '0;
    bus.dirty_we      = '0;
    bus.valid_we      = '0;
    bus.plru_we       = 1'b0;
    bus.mask_val      = '0;
    bus.data_in_sel   = 1'b0;
    bus.data_out_sel  = 1'b0;
    bus.valid_i       = 1'b0;
    bus.dirty_i       = 1'b0;
    bus.plru_i        = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read | bus.mem_write) state_d = COMPARE;
      end
      COMPARE: begin
        if (realHit) begin
          bus.mem_resp = 1'b1;
          bus.plru_we  = 1'b1;
          bus.plru_i   = plruTouch(bus.plru_o, bus.way_index);
          // A simultaneous read+write request is serviced as a write.
          if (bus.mem_write) begin
            bus.data_we  = wayOh;
            bus.mask_val = bus.mem_byte_en;
            bus.dirty_we = wayOh;
            bus.dirty_i  = 1'b1;
          end
          state_d = IDLE;
        end else if (bus.mem_read | bus.mem_write) begin
          state_d = bus.dirty_o ? WRITEBACK : ALLOCATE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.data_out_sel  = 1'b1;
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.data_we     = evictOh;
          bus.mask_val    = '1;
          bus.data_in_sel = 1'b1;
          bus.tag_we      = evictOh;
          bus.valid_we    = evictOh;
          bus.valid_i     = 1'b1;
          bus.dirty_we    = evictOh;
          bus.dirty_i     = 1'b0;
          state_d         = REFILL;
        end
      end
      REFILL:  state_d = COMPARE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end
endmodule

// File: tb/tb_single_cache_control.sv
// Self-checking bench: emulates the cache datapath and memory around the controller
// and checks every cycle against a transaction-level model of the cache contents.
module tb_single_cache_control;
  localparam int PMEM_WAIT = 3;
  localparam int NSETS     = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  single_cache_control_if #(.s_way(2), .s_mask(32)) bus ();
  single_cache_control #(.s_way(2), .s_mask(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Victim lookup and access update written out as tables for a 4-way tree.
  function automatic logic [1:0] victimOf(input logic [2:0] p);
    if (!p[0]) return p[1] ? 2'd1 : 2'd0;
    else       return p[2] ? 2'd3 : 2'd2;
  endfunction

  function automatic logic [2:0] touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    case (w)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  logic [2:0] curSet;
  logic [7:0] curTag;
  logic [7:0] tagArr   [NSETS][4] = '{default: '0};
  logic       validArr [NSETS][4];
  logic       dirtyArr [NSETS][4];
  logic [2:0] plruArr  [NSETS];
  logic       dpHit, dpValid;
  logic [1:0] dpWay;
  int         pmemCnt    = 0;
  int         pmemReads  = 0;
  int         pmemWrites = 0;

  // Tag match ignores valid so stale tags after reset exercise the valid gating.
  always_comb begin
    dpHit   = 1'b0;
    dpValid = 1'b0;
    dpWay   = 2'd0;
    for (int w = 0; w < 4; w++) begin
      if (tagArr[curSet][w] == curTag && (!dpHit || validArr[curSet][w])) begin
        dpHit   = 1'b1;
        dpValid = validArr[curSet][w];
        dpWay   = 2'(w);
      end
    end
  end

  assign bus.hit       = dpHit;
  assign bus.valid_o   = dpValid;
  assign bus.way_index = dpWay;
  assign bus.dirty_o   = dirtyArr[curSet][bus.evict_index];
  assign bus.plru_o    = plruArr[curSet];
  assign bus.pmem_resp = (bus.pmem_read | bus.pmem_write) && (pmemCnt == PMEM_WAIT - 1);

  always @(posedge clk) begin
    if (rst) begin
      pmemCnt <= 0;
      for (int s = 0; s < NSETS; s++) begin
        plruArr[s] <= 3'b000;
        for (int w = 0; w < 4; w++) begin
          validArr[s][w] <= 1'b0;
          dirtyArr[s][w] <= 1'b0;
        end
      end
    end else begin
      if (bus.pmem_resp) begin
        pmemCnt <= 0;
        if (bus.pmem_read)  pmemReads  <= pmemReads + 1;
        if (bus.pmem_write) pmemWrites <= pmemWrites + 1;
      end else if (bus.pmem_read | bus.pmem_write) begin
        pmemCnt <= pmemCnt + 1;
      end
      for (int w = 0; w < 4; w++) begin
        if (bus.tag_we[w])   tagArr[curSet][w]   <= curTag;
        if (bus.valid_we[w]) validArr[curSet][w] <= bus.valid_i;
        if (bus.dirty_we[w]) dirtyArr[curSet][w] <= bus.dirty_i;
      end
      if (bus.plru_we) plruArr[curSet] <= bus.plru_i;
    end
  end

  logic [7:0] refTag   [NSETS][4] = '{default: '0};
  logic       refValid [NSETS][4];
  logic       refDirty [NSETS][4];
  logic [2:0] refPlru  [NSETS];

  logic       active = 1'b0, done = 1'b0;
  logic       expMiss, expDirty, expWrite;
  logic [1:0] expWay;
  logic [2:0] expPlru;
  logic [31:0] expBe;
  int         expLatency, cyc, wbCycles, rdCycles, lastLatency;

  task automatic modelReset();
    for (int s = 0; s < NSETS; s++) begin
      refPlru[s] = 3'b000;
      for (int w = 0; w < 4; w++) begin
        refValid[s][w] = 1'b0;
        refDirty[s][w] = 1'b0;
      end
    end
  endtask

  // Predict one access: hit/miss, victim, dirty eviction, latency and new PLRU state.
  task automatic modelAccess(input int s, input logic [7:0] t, input logic wr);
    int way;
    way = -1;
    for (int w = 0; w < 4; w++)
      if (refValid[s][w] && refTag[s][w] == t) way = w;
    expMiss  = (way < 0);
    expDirty = 1'b0;
    if (expMiss) begin
      way            = int'(victimOf(refPlru[s]));
      expDirty       = refDirty[s][way];
      refTag[s][way]   = t;
      refValid[s][way] = 1'b1;
      refDirty[s][way] = 1'b0;
    end
    expWay     = 2'(way);
    expPlru    = touch(refPlru[s], expWay);
    refPlru[s] = expPlru;
    if (wr) refDirty[s][way] = 1'b1;
    expLatency = 2 + (expMiss ? 2 + PMEM_WAIT : 0) + (expDirty ? PMEM_WAIT : 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("evict_index", 64'(bus.evict_index), 64'(victimOf(bus.plru_o)));
      checkOutput("we_onehot", 64'({$onehot0(bus.data_we), $onehot0(bus.tag_we),
                  $onehot0(bus.valid_we), $onehot0(bus.dirty_we)}), 64'hF);
      if (active) cyc++;
      if (bus.pmem_write) begin
        checkOutput("wb_addr_sel", 64'(bus.pmem_addr_sel), 64'd1);
        checkOutput("wb_data_out_sel", 64'(bus.data_out_sel), 64'd1);
        if (active) wbCycles++;
      end
      if (bus.pmem_read) begin
        checkOutput("rd_addr_sel", 64'(bus.pmem_addr_sel), 64'd0);
        if (active) rdCycles++;
      end
      if (bus.data_we != 4'b0 && bus.data_in_sel) begin
        checkOutput("alloc_expected", 64'(active && expMiss), 64'd1);
        checkOutput("alloc_we", 64'({bus.data_we, bus.tag_we, bus.valid_we, bus.dirty_we}),
                    64'({4{4'(1 << expWay)}}));
        checkOutput("alloc_mask", 64'(bus.mask_val), 64'hFFFF_FFFF);
        checkOutput("alloc_vd", 64'({bus.valid_i, bus.dirty_i}), 64'b10);
      end else if (!bus.mem_resp) begin
        checkOutput("no_stray_we", 64'({bus.data_we, bus.tag_we, bus.valid_we, bus.dirty_we,
                    bus.plru_we}), 64'd0);
      end
      if (bus.mem_resp) begin
        checkOutput("resp_expected", 64'(active), 64'd1);
        if (active) begin
          checkOutput("latency", 64'(cyc), 64'(expLatency));
          checkOutput("wb_cycles", 64'(wbCycles), 64'(expDirty ? PMEM_WAIT : 0));
          checkOutput("rd_cycles", 64'(rdCycles), 64'(expMiss ? PMEM_WAIT : 0));
          checkOutput("plru_update", 64'({bus.plru_we, bus.plru_i}), 64'({1'b1, expPlru}));
          if (expWrite) begin
            checkOutput("wr_data_we", 64'(bus.data_we), 64'(4'(1 << expWay)));
            checkOutput("wr_dirty_we", 64'(bus.dirty_we), 64'(4'(1 << expWay)));
            checkOutput("wr_mask", 64'(bus.mask_val), 64'(expBe));
            checkOutput("wr_sel_dirty", 64'({bus.data_in_sel, bus.dirty_i, bus.tag_we}),
                        64'({1'b0, 1'b1, 4'b0}));
          end else begin
            checkOutput("rd_no_we", 64'({bus.data_we, bus.dirty_we, bus.data_out_sel}), 64'd0);
          end
          lastLatency = cyc;
          done        = 1'b1;
          active      = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input int s, input logic [7:0] t, input logic rd,
                               input logic wr, input logic [31:0] be);
    modelAccess(s, t, wr);
    expWrite        = wr;
    expBe           = be;
    cyc             = 0;
    wbCycles        = 0;
    rdCycles        = 0;
    done            = 1'b0;
    curSet          = 3'(s);
    curTag          = t;
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_byte_en = be;
    active          = 1'b1;
    for (int i = 0; i < 100 && !done; i++) @(posedge clk);
    #1;
    if (!done) begin
      checkOutput("resp_timeout", 64'd0, 64'd1);
      active = 1'b0;
    end
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_byte_en = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_byte_en = '0;
    curSet          = 3'd0;
    curTag          = 8'd0;
    modelReset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs", 64'({bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.data_we,
                bus.tag_we, bus.valid_we, bus.dirty_we, bus.plru_we, bus.mask_val}), 64'd0);
    @(posedge clk);
    #1;

    applyStimulus(3, 8'hA, 1'b1, 1'b0, 32'h0);
    checkOutput("cold_latency", 64'(lastLatency), 64'd7);
    checkOutput("cold_plru", 64'(plruArr[3]), 64'b011);
    checkOutput("cold_pmem_reads", 64'(pmemReads), 64'd1);
    checkOutput("cold_way0_valid", 64'(validArr[3][0]), 64'd1);

    applyStimulus(3, 8'hA, 1'b1, 1'b0, 32'h0);
    checkOutput("hit_latency", 64'(lastLatency), 64'd2);
    checkOutput("hit_no_pmem", 64'(pmemReads), 64'd1);
    checkOutput("hit_plru", 64'(plruArr[3]), 64'b011);

    applyStimulus(3, 8'hA, 1'b0, 1'b1, 32'h0000_000F);
    checkOutput("wr_hit_latency", 64'(lastLatency), 64'd2);
    checkOutput("wr_hit_dirty", 64'(dirtyArr[3][0]), 64'd1);

    applyStimulus(3, 8'hB, 1'b1, 1'b0, 32'h0);
    applyStimulus(3, 8'hC, 1'b1, 1'b0, 32'h0);
    applyStimulus(3, 8'hD, 1'b1, 1'b0, 32'h0);
    checkOutput("fill_plru", 64'(plruArr[3]), 64'b000);
    applyStimulus(3, 8'hE, 1'b1, 1'b0, 32'h0);
    checkOutput("dirty_latency", 64'(lastLatency), 64'd10);
    checkOutput("dirty_pmem_writes", 64'(pmemWrites), 64'd1);
    checkOutput("dirty_replaced", 64'({tagArr[3][0], dirtyArr[3][0]}), 64'({8'hE, 1'b0}));

    for (int t = 1; t <= 4; t++) applyStimulus(5, 8'(t), 1'b1, 1'b0, 32'h0);
    applyStimulus(5, 8'd1, 1'b1, 1'b0, 32'h0);
    applyStimulus(5, 8'd3, 1'b1, 1'b0, 32'h0);
    applyStimulus(5, 8'd2, 1'b1, 1'b0, 32'h0);
    applyStimulus(5, 8'd4, 1'b1, 1'b0, 32'h0);
    checkOutput("plru_seq_victim0", 64'({plruArr[5], bus.evict_index}), 64'({3'b000, 2'd0}));
    applyStimulus(5, 8'd1, 1'b1, 1'b0, 32'h0);
    checkOutput("plru_seq_victim2", 64'({plruArr[5], bus.evict_index}), 64'({3'b011, 2'd2}));

    applyStimulus(6, 8'h21, 1'b0, 1'b1, 32'h0000_FF00);
    checkOutput("wr_miss_latency", 64'(lastLatency), 64'd7);
    checkOutput("wr_miss_dirty", 64'(dirtyArr[6][0]), 64'd1);
    applyStimulus(6, 8'h21, 1'b1, 1'b1, 32'h0000_0001);
    checkOutput("rw_as_write_latency", 64'(lastLatency), 64'd2);

    curSet       = 3'd7;
    curTag       = 8'h33;
    bus.mem_read = 1'b1;
    for (int i = 0; i < 20 && !bus.pmem_read; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("alloc_reached", 64'(bus.pmem_read), 64'd1);
    rst          = 1'b1;
    bus.mem_read = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_pmem_read", 64'({bus.pmem_read, bus.pmem_write, bus.mem_resp}), 64'd0);
    checkOutput("rst_we", 64'({bus.data_we, bus.tag_we, bus.valid_we, bus.dirty_we, bus.plru_we}),
                64'd0);
    checkOutput("rst_valid_cleared", 64'({validArr[3][0], validArr[5][0], validArr[6][0]}), 64'd0);
    modelReset();
    @(posedge clk);
    #1;

    applyStimulus(3, 8'hE, 1'b1, 1'b0, 32'h0);
    checkOutput("post_rst_stale_tag_miss", 64'(lastLatency), 64'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
